// File: rtl/gnrc_fifo_pkg.sv
// Shared helpers for the generic FIFO blocks.
package gnrc_fifo_pkg;

   // Occupancy counter width: must hold every value from 0 up to dp+oq inclusive.
   function automatic int fifo_cnt_w(input int dp, input int oq);
      return $clog2(dp + oq + 1);
   endfunction

endpackage

// File: rtl/gnrc_fifo_oq.sv
// Small register FIFO with push/pop/valid; head is visible combinationally on data_o.
module gnrc_fifo_oq #(
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] L_LAST = PW'(DEPTH - 1);
   localparam logic [NW-1:0] L_FULL = NW'(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [NW-1:0] r_cnt;
   logic          w_pop;

   assign valid_o = (r_cnt != '0);
   assign data_o  = r_mem[r_rd];
   assign w_pop   = pop_i & valid_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (push_i) begin
            r_wr <= (r_wr == L_LAST) ? '0 : r_wr + PW'(1);
         end
         if (w_pop) begin
            r_rd <= (r_rd == L_LAST) ? '0 : r_rd + PW'(1);
         end
         case ({push_i, w_pop})
            2'b10:   r_cnt <= r_cnt + NW'(1);
            2'b01:   r_cnt <= r_cnt - NW'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: an entry is only visible once r_cnt says it was written.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         r_mem[r_wr] <= data_i;
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && (r_cnt == L_FULL) && !w_pop));

endmodule

// File: rtl/gnrc_dpram_fifo_ctrl.sv
// FWFT FIFO controller around an external simple dual-port RAM; reads are prefetched
// into a small output queue under a credit scheme so the RAM read latency stays hidden.
module gnrc_dpram_fifo_ctrl
   import gnrc_fifo_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DP    = 512,
   parameter int DELAY = 1,
   parameter int AW    = $clog2(DP),
   parameter int OQ    = DELAY + 1,
   parameter int CW    = fifo_cnt_w(DP, OQ)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          s_valid_i,
   output logic          s_ready_o,
   input  logic [DW-1:0] s_data_i,
   output logic          m_valid_o,
   input  logic          m_ready_i,
   output logic [DW-1:0] m_data_o,
   output logic          ram_wen_o,
   output logic          ram_we_o,
   output logic [AW-1:0] ram_waddr_o,
   output logic [DW-1:0] ram_wdata_o,
   output logic          ram_ren_o,
   output logic [AW-1:0] ram_raddr_o,
   input  logic [DW-1:0] ram_rdata_i,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int CRW = $clog2(OQ + 1);
   localparam logic [AW:0]    L_RAM_FULL   = (AW + 1)'(DP);
   localparam logic [CRW-1:0] L_CREDIT_MAX = CRW'(OQ);

   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_ram_cnt;
   logic [CRW-1:0]   r_credit;
   logic [DELAY-1:0] r_inflight;
   logic [CW-1:0]    r_count;

   logic w_push;
   logic w_fetch;
   logic w_pop;
   logic w_land;
   logic w_oq_valid;

   assign s_ready_o = (r_ram_cnt != L_RAM_FULL);
   assign w_push    = s_valid_i & s_ready_o;
   assign w_pop     = w_oq_valid & m_ready_i;
   // A pop frees a queue slot this cycle, so its credit may be spent at once;
   // without this the credit loop would leave a bubble every OQ words.
   assign w_fetch   = (r_ram_cnt != '0) & ((r_credit != '0) | w_pop);
   assign w_land    = r_inflight[DELAY-1];

   assign ram_wen_o   = w_push;
   assign ram_we_o    = w_push;
   assign ram_waddr_o = r_wptr;
   assign ram_wdata_o = s_data_i;
   assign ram_ren_o   = w_fetch;
   assign ram_raddr_o = r_rptr;

   assign m_valid_o = w_oq_valid;
   assign count_o   = r_count;
   assign full_o    = (r_ram_cnt == L_RAM_FULL);
   assign empty_o   = (r_count == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_ram_cnt  <= '0;
         r_credit   <= L_CREDIT_MAX;
         r_inflight <= '0;
         r_count    <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_fetch) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_inflight <= (r_inflight << 1) | DELAY'(w_fetch);
         case ({w_push, w_fetch})
            2'b10:   r_ram_cnt <= r_ram_cnt + (AW + 1)'(1);
            2'b01:   r_ram_cnt <= r_ram_cnt - (AW + 1)'(1);
            default: ;
         endcase
         case ({w_fetch, w_pop})
            2'b10:   r_credit <= r_credit - CRW'(1);
            2'b01:   r_credit <= r_credit + CRW'(1);
            default: ;
         endcase
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   gnrc_fifo_oq #(
      .DW    (DW),
      .DEPTH (OQ)
   ) u_oq (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_land),
      .data_i  (ram_rdata_i),
      .pop_i   (m_ready_i),
      .valid_o (w_oq_valid),
      .data_o  (m_data_o)
   );

   a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (s_valid_i && !s_ready_o) |=> (!s_valid_i || $stable(s_data_i)));

   a_credit_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_credit <= L_CREDIT_MAX);

endmodule

// File: tb/tb_gnrc_dpram_fifo_ctrl.sv
// Bench for gnrc_dpram_fifo_ctrl with DP=8 at RAM latencies 1 and 3, each backed by a RAM model.
module tb_gnrc_dpram_fifo_ctrl;

   localparam int DP = 8;

   logic        clk;
   logic        rst_n     [2];
   logic        s_valid   [2];
   logic        s_ready   [2];
   logic [15:0] s_data    [2];
   logic        m_valid   [2];
   logic        m_ready   [2];
   logic [15:0] m_data    [2];
   logic        ram_wen   [2];
   logic        ram_we    [2];
   logic [2:0]  ram_waddr [2];
   logic [15:0] ram_wdata [2];
   logic        ram_ren   [2];
   logic [2:0]  ram_raddr [2];
   logic [15:0] ram_rdata [2];
   logic [3:0]  count     [2];
   logic        full      [2];
   logic        empty     [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cur_d    = 0;

   // reference model: contents in order plus write/read address sequence counters
   logic [15:0] exp_q[$];
   int model_cnt;
   int push_idx;
   int fetch_idx;
   int wrap_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   gnrc_dpram_fifo_ctrl #(.DW(16), .DP(DP), .DELAY(1)) u_dut_d1 (
      .clk_i(clk), .rst_ni(rst_n[0]),
      .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]), .s_data_i(s_data[0]),
      .m_valid_o(m_valid[0]), .m_ready_i(m_ready[0]), .m_data_o(m_data[0]),
      .ram_wen_o(ram_wen[0]), .ram_we_o(ram_we[0]), .ram_waddr_o(ram_waddr[0]),
      .ram_wdata_o(ram_wdata[0]), .ram_ren_o(ram_ren[0]), .ram_raddr_o(ram_raddr[0]),
      .ram_rdata_i(ram_rdata[0]), .count_o(count[0]), .full_o(full[0]), .empty_o(empty[0])
   );

   gnrc_dpram_fifo_ctrl #(.DW(16), .DP(DP), .DELAY(3)) u_dut_d3 (
      .clk_i(clk), .rst_ni(rst_n[1]),
      .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]), .s_data_i(s_data[1]),
      .m_valid_o(m_valid[1]), .m_ready_i(m_ready[1]), .m_data_o(m_data[1]),
      .ram_wen_o(ram_wen[1]), .ram_we_o(ram_we[1]), .ram_waddr_o(ram_waddr[1]),
      .ram_wdata_o(ram_wdata[1]), .ram_ren_o(ram_ren[1]), .ram_raddr_o(ram_raddr[1]),
      .ram_rdata_i(ram_rdata[1]), .count_o(count[1]), .full_o(full[1]), .empty_o(empty[1])
   );

   // read-first RAM models with 1 and 3 cycles of read latency
   logic [15:0] mem_d1 [DP];
   logic [15:0] mem_d3 [DP];
   logic [15:0] pipe_d1;
   logic [15:0] pipe_d3 [3];

   always @(posedge clk) begin
      if (ram_wen[0] && ram_we[0]) mem_d1[ram_waddr[0]] <= ram_wdata[0];
      if (ram_ren[0]) pipe_d1 <= mem_d1[ram_raddr[0]];
      if (ram_wen[1] && ram_we[1]) mem_d3[ram_waddr[1]] <= ram_wdata[1];
      if (ram_ren[1]) pipe_d3[0] <= mem_d3[ram_raddr[1]];
      pipe_d3[1] <= pipe_d3[0];
      pipe_d3[2] <= pipe_d3[1];
   end

   assign ram_rdata[0] = pipe_d1;
   assign ram_rdata[1] = pipe_d3[2];

   function automatic int delay_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int oq_of(input int d);
      return delay_of(d) + 1;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (delay %0d) @%0t: got 0x%0h, expected 0x%0h", tag, delay_of(cur_d), $time, got, exp);
      end
   endtask

   // Inputs are driven just after a rising edge; this samples mid-cycle, checks,
   // updates the model with the handshakes that will fire, and returns after the next edge.
   task automatic tick(input int d);
      logic push;
      logic pop;
      logic [15:0] tmp;
      #1;
      push = s_valid[d] & s_ready[d];
      pop  = m_valid[d] & m_ready[d];
      check_val("count", 32'(count[d]), model_cnt);
      check_val("empty", 32'(empty[d]), 32'(model_cnt == 0));
      check_val("full_vs_ready", 32'(full[d]), 32'(!s_ready[d]));
      if (model_cnt == 0) check_val("no_stale_valid", 32'(m_valid[d]), 0);
      if (model_cnt < DP) check_val("ready_not_full", 32'(s_ready[d]), 1);
      if (model_cnt == DP + oq_of(d)) check_val("ready_at_capacity", 32'(s_ready[d]), 0);
      if (m_valid[d] && exp_q.size() > 0) check_val("data", 32'(m_data[d]), 32'(exp_q[0]));
      if (push) begin
         check_val("wen_we", {30'd0, ram_wen[d], ram_we[d]}, 3);
         check_val("waddr", 32'(ram_waddr[d]), push_idx % DP);
         check_val("wdata", 32'(ram_wdata[d]), 32'(s_data[d]));
         if (ram_waddr[d] == 3'(DP - 1)) wrap_cnt++;
         exp_q.push_back(s_data[d]);
      end else begin
         check_val("wen_idle", 32'(ram_wen[d]), 0);
      end
      if (ram_ren[d]) begin
         check_val("fetch_after_write", 32'(fetch_idx < push_idx), 1);
         check_val("raddr", 32'(ram_raddr[d]), fetch_idx % DP);
         fetch_idx++;
      end
      if (pop && exp_q.size() > 0) tmp = exp_q.pop_front();
      model_cnt = model_cnt + int'(push) - int'(pop);
      if (push) push_idx++;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      exp_q.delete();
      model_cnt = 0;
      push_idx  = 0;
      fetch_idx = 0;
      wrap_cnt  = 0;
   endtask

   task automatic do_reset(input int d);
      s_valid[d] = 1'b0;
      m_ready[d] = 1'b0;
      s_data[d]  = '0;
      rst_n[d]   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n[d] = 1'b1;
      model_clear();
   endtask

   task automatic drain(input int d);
      s_valid[d] = 1'b0;
      m_ready[d] = 1'b1;
      for (int k = 0; k < 200 && model_cnt > 0; k++) tick(d);
      check_val("drained", 32'(count[d]), 0);
      m_ready[d] = 1'b0;
   endtask

   task automatic wait_valid(input int d);
      for (int k = 0; k < 30 && !m_valid[d]; k++) tick(d);
      check_val("wait_valid", 32'(m_valid[d]), 1);
   endtask

   task automatic run_all(input int d);
      int lat;
      int n;
      int got;
      int nxt;
      int first;
      int pushed;
      logic hold;
      cur_d = d;

      // 1: reset state, single word latency
      do_reset(d);
      check_val("rst_ready", 32'(s_ready[d]), 1);
      check_val("rst_valid", 32'(m_valid[d]), 0);
      check_val("rst_count", 32'(count[d]), 0);
      check_val("rst_full", 32'(full[d]), 0);
      check_val("rst_empty", 32'(empty[d]), 1);
      check_val("rst_wen", 32'(ram_wen[d]), 0);
      check_val("rst_ren", 32'(ram_ren[d]), 0);
      s_valid[d] = 1'b1;
      s_data[d]  = 16'h00A5;
      tick(d);
      s_valid[d] = 1'b0;
      lat = 1;
      while (!m_valid[d] && lat < 20) begin
         tick(d);
         lat++;
      end
      check_val("latency", lat, 2 + delay_of(d));
      check_val("single_data", 32'(m_data[d]), 32'h00A5);
      m_ready[d] = 1'b1;
      tick(d);
      m_ready[d] = 1'b0;
      check_val("single_popped", 32'(count[d]), 0);

      // 2: fill to capacity with the consumer stalled
      do_reset(d);
      n = 0;
      for (int c = 0; c < 80 && n < DP + oq_of(d); c++) begin
         s_valid[d] = 1'b1;
         s_data[d]  = 16'h0100 + 16'(n);
         tick(d);
         n = model_cnt;
      end
      check_val("fill_words", n, DP + oq_of(d));
      s_data[d] = 16'hBEEF;
      repeat (6) tick(d);
      check_val("full_flag", 32'(full[d]), 1);
      check_val("full_ready", 32'(s_ready[d]), 0);
      check_val("full_count", 32'(count[d]), DP + oq_of(d));
      drain(d);

      // 3: continuous streaming of 0..99
      do_reset(d);
      nxt = 0;
      got = 0;
      first = -1;
      m_ready[d] = 1'b1;
      for (int c = 0; c < 300 && got < 100; c++) begin
         s_valid[d] = (nxt < 100);
         s_data[d]  = 16'(nxt);
         if (first >= 0) check_val("no_bubble", 32'(m_valid[d]), 1);
         if (m_valid[d]) begin
            if (first < 0) first = c;
            got++;
         end
         if (s_valid[d] && s_ready[d]) nxt++;
         tick(d);
      end
      s_valid[d] = 1'b0;
      m_ready[d] = 1'b0;
      check_val("stream_first", first, 2 + delay_of(d));
      check_val("stream_in", nxt, 100);
      check_val("stream_out", got, 100);
      check_val("stream_wraps", 32'(wrap_cnt >= 12), 1);

      // 4: random valid/ready, 2000 words
      do_reset(d);
      pushed = 0;
      hold = 1'b0;
      for (int c = 0; c < 30000 && (pushed < 2000 || model_cnt > 0); c++) begin
         if (!hold) begin
            s_valid[d] = (pushed < 2000) && ($urandom_range(0, 1) == 1);
            s_data[d]  = 16'($urandom);
         end
         m_ready[d] = ($urandom_range(0, 1) == 1);
         hold = s_valid[d] & !s_ready[d];
         if (s_valid[d] && s_ready[d]) pushed++;
         tick(d);
      end
      s_valid[d] = 1'b0;
      m_ready[d] = 1'b0;
      check_val("rand_pushed", pushed, 2000);
      check_val("rand_empty", 32'(count[d]), 0);

      // 5: reset in the middle of a cycle while holding data
      do_reset(d);
      for (int c = 0; c < 20 && model_cnt < 5; c++) begin
         s_valid[d] = 1'b1;
         s_data[d]  = 16'h0200 + 16'(model_cnt);
         tick(d);
      end
      s_valid[d] = 1'b0;
      repeat (3) tick(d);
      check_val("pre_rst_valid", 32'(m_valid[d]), 1);
      #2;
      rst_n[d] = 1'b0;
      #1;
      check_val("mid_rst_count", 32'(count[d]), 0);
      check_val("mid_rst_empty", 32'(empty[d]), 1);
      check_val("mid_rst_valid", 32'(m_valid[d]), 0);
      check_val("mid_rst_ready", 32'(s_ready[d]), 1);
      check_val("mid_rst_full", 32'(full[d]), 0);
      @(posedge clk);
      #1;
      rst_n[d] = 1'b1;
      model_clear();
      m_ready[d] = 1'b1;
      repeat (12) tick(d);
      s_valid[d] = 1'b1;
      s_data[d]  = 16'h005A;
      tick(d);
      drain(d);

      // 6: push and pop in the same cycle at count 1
      do_reset(d);
      s_valid[d] = 1'b1;
      s_data[d]  = 16'h0061;
      tick(d);
      s_valid[d] = 1'b0;
      wait_valid(d);
      s_valid[d] = 1'b1;
      s_data[d]  = 16'h0062;
      m_ready[d] = 1'b1;
      tick(d);
      s_valid[d] = 1'b0;
      m_ready[d] = 1'b0;
      check_val("pushpop_count", 32'(count[d]), 1);
      wait_valid(d);
      check_val("pushpop_order", 32'(m_data[d]), 32'h0062);
      drain(d);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d]   = 1'b0;
         s_valid[d] = 1'b0;
         m_ready[d] = 1'b0;
         s_data[d]  = '0;
      end
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) run_all(d);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL timeout: got still running, expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
